// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam int         FWD_RS1  = 1;
    localparam int         FWD_RS2  = 0;
    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// fwd_match: compares one ID source operand against the EX, MEM and WB producers.
// Returns a one-hot hit, youngest producer first.
module fwd_match
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic       ex_hit,
    output logic       mem_hit,
    output logic       wb_hit
);

    logic ex_cand, mem_cand, wb_cand;

    assign ex_cand  = use_src && ex_regwrite  && (ex_rd  != REG_ZERO) && (ex_rd  == src);
    assign mem_cand = use_src && mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == src);
    assign wb_cand  = use_src && wb_regwrite  && (wb_rd  != REG_ZERO) && (wb_rd  == src);

    assign ex_hit  = ex_cand;
    assign mem_hit = mem_cand && !ex_cand;
    assign wb_hit  = wb_cand && !ex_cand && !mem_cand;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard sequencing and forwarding selects for the 5-stage RV32I core.
// Define HAZARD_MEM_WAIT_EN to build the data-memory wait path (MEM_WAIT, timeout, stall-load capture).
//
// state    | meaning
// RUN      | normal issue, hazards evaluated
// LD_STALL | one bubble after a load-use hazard
// MEM_WAIT | data memory not ready, pipe frozen
// FLUSH    | second squash cycle after a taken branch
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic [31:0] wb_data,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_keep,
    output logic        ifid_keep,
    output logic        idex_keep,
    output logic        exmem_keep,
    output logic        ifid_nop,
    output logic        idex_nop,
    output logic        memwb_nop,
    output logic [1:0]  fwd_ex_pyc,
    output logic [1:0]  fwd_mem_pyc,
    output logic [1:0]  fwd_mem_hazard_pyc,
    output logic [1:0]  fwd_stall_load_pyc,
    output logic [31:0] fwd_load_data,
    output logic        mem_timeout
);

    state_t     state, state_next;
    logic       wait_cond, ld_use, freeze;
    logic [1:0] hit_ex, hit_mem, hit_wb, cap;
    logic [1:0] sel_ex, sel_mem, sel_wb;

    assign ld_use = ex_is_load && ex_regwrite && (ex_rd != REG_ZERO) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef HAZARD_MEM_WAIT_EN
    assign wait_cond = dmem_req && !dmem_ready;
`else
    assign wait_cond = 1'b0;
`endif

    // Mealy controls; held at zero while rst is high so nothing leaks out of reset.
    always_comb begin
        state_next = state;
        freeze     = 1'b0;
        pc_keep    = 1'b0;
        ifid_keep  = 1'b0;
        idex_keep  = 1'b0;
        ifid_nop   = 1'b0;
        idex_nop   = 1'b0;
        if (!rst) begin
            case (state)
                RUN, LD_STALL, FLUSH: begin
                    if (wait_cond) begin
                        state_next = MEM_WAIT;
                        freeze     = 1'b1;
                    end else if (branch_taken) begin
                        state_next = FLUSH;
                        ifid_nop   = 1'b1;
                        idex_nop   = 1'b1;
                    end else if (state == FLUSH) begin
                        state_next = RUN;
                        idex_nop   = 1'b1;
                    end else if (ld_use) begin
                        state_next = LD_STALL;
                        pc_keep    = 1'b1;
                        ifid_keep  = 1'b1;
                        idex_nop   = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
`ifdef HAZARD_MEM_WAIT_EN
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        freeze = 1'b1;
                    end else if (branch_taken) begin
                        state_next = FLUSH;
                        ifid_nop   = 1'b1;
                        idex_nop   = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
`endif
                default: state_next = RUN;
            endcase
            if (freeze) begin
                pc_keep   = 1'b1;
                ifid_keep = 1'b1;
                idex_keep = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    fwd_match u_match_rs1 (
        .src          (id_rs1),
        .use_src      (id_use_rs1),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .ex_hit       (hit_ex[FWD_RS1]),
        .mem_hit      (hit_mem[FWD_RS1]),
        .wb_hit       (hit_wb[FWD_RS1])
    );

    fwd_match u_match_rs2 (
        .src          (id_rs2),
        .use_src      (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .ex_hit       (hit_ex[FWD_RS2]),
        .mem_hit      (hit_mem[FWD_RS2]),
        .wb_hit       (hit_wb[FWD_RS2])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_ex  <= '0;
            sel_mem <= '0;
            sel_wb  <= '0;
        end else if (!idex_keep) begin
            sel_ex  <= idex_nop ? 2'b00 : hit_ex;
            sel_mem <= idex_nop ? 2'b00 : hit_mem;
            sel_wb  <= idex_nop ? 2'b00 : hit_wb;
        end else begin
            sel_wb  <= sel_wb & ~cap;
        end
    end

    assign fwd_ex_pyc         = sel_ex;
    assign fwd_mem_pyc        = sel_mem;
    assign fwd_mem_hazard_pyc = sel_wb;

`ifdef HAZARD_MEM_WAIT_EN
    logic [7:0]  wait_cnt, cnt_inc;
    logic        timeout_q, enter_wait, wb_ok;
    logic [4:0]  src_rs1, src_rs2;
    logic [1:0]  sel_sl;
    logic [31:0] load_q;

    assign cnt_inc    = sat_inc(wait_cnt);
    assign enter_wait = freeze && (state != MEM_WAIT);
    assign wb_ok      = wb_regwrite && (wb_rd != REG_ZERO);

    // The producer still sits in WB on the cycle the wait begins; grab it before memwb bubbles it out.
    assign cap[FWD_RS1] = enter_wait && sel_wb[FWD_RS1] && wb_ok && (wb_rd == src_rs1);
    assign cap[FWD_RS2] = enter_wait && sel_wb[FWD_RS2] && wb_ok && (wb_rd == src_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state_next == MEM_WAIT) begin
            wait_cnt <= cnt_inc;
            if (cnt_inc >= 8'(WAIT_MAX)) timeout_q <= 1'b1;
        end else if ((state == MEM_WAIT) && (state_next == RUN)) begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_rs1 <= '0;
            src_rs2 <= '0;
            sel_sl  <= '0;
            load_q  <= '0;
        end else begin
            if (!idex_keep) begin
                src_rs1 <= idex_nop ? REG_ZERO : id_rs1;
                src_rs2 <= idex_nop ? REG_ZERO : id_rs2;
                sel_sl  <= '0;
            end else begin
                sel_sl  <= sel_sl | cap;
            end
            if (|cap) load_q <= wb_data;
        end
    end

    assign exmem_keep         = freeze;
    assign memwb_nop          = freeze;
    assign mem_timeout        = timeout_q;
    assign fwd_stall_load_pyc = sel_sl;
    assign fwd_load_data      = load_q;
`else
    logic unused_mem;
    assign unused_mem = ^{dmem_req, dmem_ready, wb_data, 8'(WAIT_MAX)};

    assign cap                = 2'b00;
    assign exmem_keep         = 1'b0;
    assign memwb_nop          = 1'b0;
    assign mem_timeout        = 1'b0;
    assign fwd_stall_load_pyc = 2'b00;
    assign fwd_load_data      = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Memory-wait scenarios run only when HAZARD_MEM_WAIT_EN is defined.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite, wb_regwrite;
    logic [31:0] wb_data;
    logic        branch_taken, dmem_req, dmem_ready;
    logic        pc_keep, ifid_keep, idex_keep, exmem_keep, ifid_nop, idex_nop, memwb_nop;
    logic [1:0]  fwd_ex_pyc, fwd_mem_pyc, fwd_mem_hazard_pyc, fwd_stall_load_pyc;
    logic [31:0] fwd_load_data;
    logic        mem_timeout;
    logic [6:0]  ctl;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.WAIT_MAX(15)) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_use_rs1         (id_use_rs1),
        .id_use_rs2         (id_use_rs2),
        .ex_rd              (ex_rd),
        .ex_regwrite        (ex_regwrite),
        .ex_is_load         (ex_is_load),
        .mem_rd             (mem_rd),
        .mem_regwrite       (mem_regwrite),
        .wb_rd              (wb_rd),
        .wb_regwrite        (wb_regwrite),
        .wb_data            (wb_data),
        .branch_taken       (branch_taken),
        .dmem_req           (dmem_req),
        .dmem_ready         (dmem_ready),
        .pc_keep            (pc_keep),
        .ifid_keep          (ifid_keep),
        .idex_keep          (idex_keep),
        .exmem_keep         (exmem_keep),
        .ifid_nop           (ifid_nop),
        .idex_nop           (idex_nop),
        .memwb_nop          (memwb_nop),
        .fwd_ex_pyc         (fwd_ex_pyc),
        .fwd_mem_pyc        (fwd_mem_pyc),
        .fwd_mem_hazard_pyc (fwd_mem_hazard_pyc),
        .fwd_stall_load_pyc (fwd_stall_load_pyc),
        .fwd_load_data      (fwd_load_data),
        .mem_timeout        (mem_timeout)
    );

    // {pc_keep, ifid_keep, idex_keep, exmem_keep, ifid_nop, idex_nop, memwb_nop}
    assign ctl = {pc_keep, ifid_keep, idex_keep, exmem_keep, ifid_nop, idex_nop, memwb_nop};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0;
        wb_rd = 5'd0; wb_regwrite = 1'b0; wb_data = 32'd0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        branch_taken = 1'b1;
        settle();
        chk("reset_ctl_gated", 32'(ctl), 32'd0);
        tick();
        tick();
        chk("reset_fwd_ex", 32'(fwd_ex_pyc), 32'd0);
        chk("reset_fwd_mem", 32'(fwd_mem_pyc), 32'd0);
        chk("reset_fwd_wb", 32'(fwd_mem_hazard_pyc), 32'd0);
        chk("reset_fwd_sl", 32'(fwd_stall_load_pyc), 32'd0);
        chk("reset_load_data", fwd_load_data, 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);
        rst = 1'b0;
        idle();
        settle();
        chk("run_idle_ctl", 32'(ctl), 32'd0);
        tick();

        // lw x5 in EX, add in ID reads x5 on rs1
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd6; id_use_rs2 = 1'b1;
        settle();
        chk("ld_use_ctl", 32'(ctl), 32'b1100010);
        tick();
        chk("ld_use_bubble_sel", 32'({fwd_ex_pyc, fwd_mem_pyc, fwd_mem_hazard_pyc}), 32'd0);
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
        mem_rd = 5'd5; mem_regwrite = 1'b1;
        settle();
        chk("ld_stall_no_refire", 32'(ctl), 32'd0);
        tick();
        chk("ld_use_fwd_mem", 32'(fwd_mem_pyc), 32'b10);
        chk("ld_use_fwd_ex", 32'(fwd_ex_pyc), 32'b00);

        // add x3 in EX and MEM, sub reads x3 on rs2: EX wins
        idle();
        ex_rd = 5'd3; ex_regwrite = 1'b1; mem_rd = 5'd3; mem_regwrite = 1'b1;
        id_rs1 = 5'd4; id_use_rs1 = 1'b1; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        settle();
        chk("alu_dep_no_stall", 32'(ctl), 32'd0);
        tick();
        chk("ex_prio_fwd_ex", 32'(fwd_ex_pyc), 32'b01);
        chk("ex_prio_fwd_mem", 32'(fwd_mem_pyc), 32'b00);

        // MEM feeds rs2, WB feeds rs1
        ex_regwrite = 1'b0;
        wb_rd = 5'd4; wb_regwrite = 1'b1;
        tick();
        chk("mix_fwd_ex", 32'(fwd_ex_pyc), 32'b00);
        chk("mix_fwd_mem", 32'(fwd_mem_pyc), 32'b01);
        chk("mix_fwd_wb", 32'(fwd_mem_hazard_pyc), 32'b10);

        // taken branch while a load-use is present
        idle();
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        branch_taken = 1'b1;
        settle();
        chk("branch_ctl", 32'(ctl), 32'b0000110);
        tick();
        chk("branch_sel_cleared", 32'({fwd_ex_pyc, fwd_mem_pyc, fwd_mem_hazard_pyc}), 32'd0);
        branch_taken = 1'b0;
        settle();
        chk("flush_ctl", 32'(ctl), 32'b0000010);
        tick();
        idle();
        settle();
        chk("after_flush_ctl", 32'(ctl), 32'd0);
        tick();

        // producer rd = x0 never forwards, even after a live select
        mem_rd = 5'd9; mem_regwrite = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        tick();
        chk("pre_x0_fwd_mem", 32'(fwd_mem_pyc), 32'b10);
        idle();
        ex_rd = 5'd0; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        mem_rd = 5'd0; mem_regwrite = 1'b1; wb_rd = 5'd0; wb_regwrite = 1'b1;
        id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        settle();
        chk("x0_load_no_stall", 32'(ctl), 32'd0);
        tick();
        chk("x0_all_sel", 32'({fwd_ex_pyc, fwd_mem_pyc, fwd_mem_hazard_pyc}), 32'd0);

        // use flag low blocks a matching producer
        idle();
        ex_rd = 5'd8; ex_regwrite = 1'b1; id_rs2 = 5'd8; id_use_rs2 = 1'b0;
        tick();
        chk("use_flag_off", 32'(fwd_ex_pyc), 32'b00);

`ifdef HAZARD_MEM_WAIT_EN
        // WB producer x7 pending on rs1, then memory stalls 3 cycles
        idle();
        id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        wb_rd = 5'd7; wb_regwrite = 1'b1; wb_data = 32'h11111111;
        tick();
        chk("pend_fwd_wb", 32'(fwd_mem_hazard_pyc), 32'b10);
        dmem_req = 1'b1; dmem_ready = 1'b0; wb_data = 32'hDEADBEEF;
        settle();
        chk("wait1_ctl", 32'(ctl), 32'b1111001);
        tick();
        chk("capture_data", fwd_load_data, 32'hDEADBEEF);
        chk("capture_sl_sel", 32'(fwd_stall_load_pyc), 32'b10);
        chk("capture_wb_sel", 32'(fwd_mem_hazard_pyc), 32'b00);
        wb_rd = 5'd0; wb_regwrite = 1'b0; wb_data = 32'h0;
        settle();
        chk("wait2_ctl", 32'(ctl), 32'b1111001);
        tick();
        settle();
        chk("wait3_ctl", 32'(ctl), 32'b1111001);
        tick();
        chk("wait_hold_sl_sel", 32'(fwd_stall_load_pyc), 32'b10);
        dmem_ready = 1'b1;
        settle();
        chk("release_ctl", 32'(ctl), 32'd0);
        tick();
        chk("load_data_holds", fwd_load_data, 32'hDEADBEEF);
        chk("short_wait_no_timeout", 32'(mem_timeout), 32'd0);

        // 20-cycle wait against WAIT_MAX = 15
        idle();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            settle();
            if (i == 1 || i == 20) chk($sformatf("long_wait_ctl_%0d", i), 32'(ctl), 32'b1111001);
            tick();
            chk($sformatf("timeout_%0d", i), 32'(mem_timeout), (i >= 15) ? 32'd1 : 32'd0);
        end
        rst = 1'b1;
        settle();
        chk("rst_mid_wait_ctl", 32'(ctl), 32'd0);
        tick();
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_load_data", fwd_load_data, 32'd0);
        chk("rst_sl_sel", 32'(fwd_stall_load_pyc), 32'd0);
        rst = 1'b0;
        idle();
        settle();
        chk("post_rst_ctl", 32'(ctl), 32'd0);
        tick();

        // ready and branch together in MEM_WAIT: release and flush at once
        dmem_req = 1'b1; dmem_ready = 1'b0;
        settle();
        chk("wb_wait_ctl", 32'(ctl), 32'b1111001);
        tick();
        dmem_ready = 1'b1; branch_taken = 1'b1;
        settle();
        chk("release_flush_ctl", 32'(ctl), 32'b0000110);
        tick();
        idle();
        settle();
        chk("release_flush2_ctl", 32'(ctl), 32'b0000010);
        tick();
        settle();
        chk("release_flush_done", 32'(ctl), 32'd0);
        tick();
`else
        // without the wait path dmem_ready is ignored
        idle();
        id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        wb_rd = 5'd7; wb_regwrite = 1'b1; wb_data = 32'hDEADBEEF;
        tick();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        settle();
        chk("nowait_ctl", 32'(ctl), 32'd0);
        tick();
        chk("nowait_timeout", 32'(mem_timeout), 32'd0);
        chk("nowait_sl_sel", 32'(fwd_stall_load_pyc), 32'd0);
        chk("nowait_load_data", fwd_load_data, 32'd0);
        chk("nowait_fwd_wb", 32'(fwd_mem_hazard_pyc), 32'b10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and forwarding controller for the 5-stage RV32I core. Sequences the IF/ID, ID/EX and EX/MEM pipeline registers with per-stage `keep` (hold) and `nop` (bubble) controls. Resolves load-use, branch-flush and data-memory wait hazards. Produces the registered 2-bit forwarding selects and the held load-data word that the execute stage consumes; bit1 of each select steers rs1 and bit0 steers rs2.

## Interface
- `WAIT_MAX`, 15: data-memory wait cycles allowed before `mem_timeout` sets; range 1..255.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction reads rs1 / rs2.
- `ex_rd` in 5, `ex_regwrite` in 1, `ex_is_load` in 1: destination, write enable and load flag of the instruction in EX.
- `mem_rd` in 5, `mem_regwrite` in 1: destination and write enable of the instruction in MEM.
- `wb_rd` in 5, `wb_regwrite` in 1, `wb_data` in 32: the instruction in WB and its write-back value.
- `branch_taken` in 1: branch or jump resolved taken in MEM.
- `dmem_req` in 1, `dmem_ready` in 1: MEM-stage memory access and its completion.
- `pc_keep`, `ifid_keep`, `idex_keep`, `exmem_keep` out 1: hold the PC or the named pipeline register.
- `ifid_nop`, `idex_nop`, `memwb_nop` out 1: load a bubble into the named register.
- `fwd_ex_pyc`, `fwd_mem_pyc`, `fwd_mem_hazard_pyc`, `fwd_stall_load_pyc` out 2: forwarding selects, registered and aligned with ID/EX.
- `fwd_load_data` out 32: captured write-back value for the stall-load path.
- `mem_timeout` out 1: sticky timeout flag.

## Operation
- FSM states: RUN, LD_STALL, MEM_WAIT, FLUSH.
- Reset forces RUN and clears every output to 0, including the `fwd_load_data` register, the wait counter and `mem_timeout`.
- Hazard priority is MEM_WAIT > FLUSH > LD_STALL.
- **Memory wait.** Condition: `dmem_req && !dmem_ready` in RUN, LD_STALL or FLUSH.
  - Go to MEM_WAIT.
  - Assert `pc_keep`, `ifid_keep`, `idex_keep`, `exmem_keep` and `memwb_nop` while in MEM_WAIT.
  - The wait counter increments each MEM_WAIT cycle and saturates at 255.
  - When the count reaches `WAIT_MAX`, `mem_timeout` sets and stays set until `rst`.
  - On `dmem_ready`, leave MEM_WAIT:
    - to FLUSH if `branch_taken` is high;
    - otherwise to RUN, and the counter clears.
- **Flush.** Condition: `branch_taken` with no memory wait.
  - Assert `ifid_nop` and `idex_nop` in that cycle.
  - Go to FLUSH for exactly one cycle. In FLUSH, assert `idex_nop` only.
  - A load-use condition detected in that cycle is discarded.
- **Load-use.** Condition: `ex_is_load && ex_regwrite && ex_rd!=0`, with `(id_use_rs1 && id_rs1==ex_rd)` or `(id_use_rs2 && id_rs2==ex_rd)`.
  - Assert `pc_keep`, `ifid_keep` and `idex_nop`.
  - Enter LD_STALL for one cycle, then return to RUN.
  - The load-use condition cannot re-fire in LD_STALL, because EX then holds the bubble.
- **Forwarding select update.** Per operand, on each cycle where `idex_keep` is 0:
  - Match order is youngest-first: EX stage → `fwd_ex_pyc`; else MEM stage → `fwd_mem_pyc`; else WB stage → `fwd_mem_hazard_pyc`.
  - A match needs the producer's regwrite high, producer rd equal to the operand source, rd != 0, and the use flag set.
  - At most one select bit per operand is set.
  - When `idex_nop` is asserted, all selects load 0.
- **Stall-load capture.** Applies on the first MEM_WAIT cycle.
  - Condition: the WB instruction (`wb_regwrite`, `wb_rd` != 0) matches the operand whose held `fwd_mem_hazard_pyc` bit is set.
  - Capture `wb_data` into `fwd_load_data`.
  - Move that operand's bit from `fwd_mem_hazard_pyc` to `fwd_stall_load_pyc`.
  - `fwd_load_data` holds until the next capture.

## Timing
- `keep`/`nop` outputs are Mealy: combinational from state and inputs in the same cycle.
- Forwarding selects register on the same edge at which ID/EX loads, so they are valid for the whole EX cycle of the consuming instruction.
- Latencies:
  - load-use costs exactly 1 bubble;
  - a taken branch costs 2 squashed slots, over 2 cycles;
  - a memory wait of N cycles freezes the pipe for N cycles.
- Simultaneous `dmem_ready` and `branch_taken` in MEM_WAIT: release and flush in the same cycle.
- `rst` asserted mid-wait or mid-flush: RUN on the next edge, with no residual `keep`/`nop`.

## Configuration
- `HAZARD_MEM_WAIT_EN` defined: MEM_WAIT state, wait counter, `mem_timeout` and stall-load capture are present as described above.
- Macro undefined:
  - `dmem_ready` is ignored and treated as always 1;
  - MEM_WAIT is unreachable;
  - `exmem_keep`, `memwb_nop`, `mem_timeout` and `fwd_stall_load_pyc` are tied to 0;
  - `fwd_load_data` is tied to 0.

## Structure
- Shared package `hazard_pkg` holds:
  - the FSM state enum;
  - the select bit positions `FWD_RS1=1`, `FWD_RS2=0`;
  - `REG_ZERO=5'd0`.
- One sub-module, `fwd_match`: per-operand producer comparator returning the one-hot ex/mem/wb match. Instantiated twice, once per operand.

## Test plan
- lw x5 in EX, ID add reads x5 → one cycle with `pc_keep=1`, `ifid_keep=1`, `idex_nop=1`. Next cycle back in RUN with `fwd_mem_pyc=2'b10`.
- add x3 in EX, ID sub reads x3 on rs2 → `fwd_ex_pyc=2'b01`. The same rd also in MEM still gives EX priority.
- Producer rd=x0 with regwrite high → all selects 0.
- `branch_taken` pulse with a load-use present → `ifid_nop=1` and `idex_nop=1`, then `idex_nop=1` for one further cycle; no load-use stall.
- `dmem_req` high with `dmem_ready` low for 3 cycles, WB writing x7=0xDEADBEEF with the consumer's x7 forward pending → all keeps high for 3 cycles, `fwd_load_data=0xDEADBEEF`, `fwd_stall_load_pyc=2'b10`.
- `dmem_ready` low for 20 cycles with `WAIT_MAX=15` → `mem_timeout` rises after the 15th cycle; `rst` clears it and all outputs.
